// File: rtl/keccak_msg_feeder.sv
// keccak_msg_feeder: packs a valid/ready byte stream into big-endian 32-bit
// words for the keccak core's input port. When a message ends it waits for the
// digest, signals completion and pulses the core reset.
// Optional build macro KECCAK_FEEDER_LENCNT_EN adds the msg_len byte counter output.
module keccak_msg_feeder #(
  parameter bit PAD_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_byte,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] k_in,
  output logic        k_in_ready,
  output logic        k_is_last,
  output logic [1:0]  k_byte_num,
  input  logic        k_buffer_full,
  input  logic        k_out_ready,
  output logic        k_reset,
  output logic        msg_done,
`ifdef KECCAK_FEEDER_LENCNT_EN
  output logic [31:0] msg_len,
`endif
  output logic        busy
);

  typedef enum logic [2:0] {FILL, PAD, WAIT_DIG, DONE, CORE_RST} state_t;

  state_t      state, state_nxt;
  logic [23:0] acc, acc_ins;
  logic [1:0]  cnt;
  logic        pend;
  logic        xfer, hold_free, accept;
  logic        ld, ld_last;
  logic [31:0] ld_data;
  logic [1:0]  ld_bnum;

  // Partial last word: bytes beyond n are zeroed when PAD_ZERO is set.
  function automatic logic [31:0] mk_word(input logic [23:0] a, input logic [1:0] n);
    logic [31:0] w;
    w = {a, 8'h00};
    if (PAD_ZERO) begin
      case (n)
        2'd1:    w = w & 32'hFF00_0000;
        2'd2:    w = w & 32'hFFFF_0000;
        default: w = w & 32'hFFFF_FF00;
      endcase
    end
    return w;
  endfunction

  assign xfer      = k_in_ready & ~k_buffer_full;
  assign hold_free = ~k_in_ready | xfer;

  // Accumulator with the incoming byte placed at the current byte position.
  always_comb begin
    acc_ins = acc;
    case (cnt)
      2'd0:    acc_ins[23:16] = s_byte;
      2'd1:    acc_ins[15:8]  = s_byte;
      2'd2:    acc_ins[7:0]   = s_byte;
      default: acc_ins        = acc;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (pend) begin
          if (hold_free) state_nxt = WAIT_DIG;
        end else if (accept && s_last) begin
          if (cnt == 2'd3)    state_nxt = PAD;
          else if (hold_free) state_nxt = WAIT_DIG;
        end
      end
      PAD:      if (hold_free) state_nxt = WAIT_DIG;
      WAIT_DIG: if (!k_in_ready && k_out_ready) state_nxt = DONE;
      DONE:     state_nxt = CORE_RST;
      CORE_RST: state_nxt = FILL;
      default:  state_nxt = FILL;
    endcase
  end

  // Output and hold-register load decode.
  always_comb begin
    s_ready  = 1'b0;
    accept   = 1'b0;
    ld       = 1'b0;
    ld_data  = k_in;
    ld_last  = 1'b0;
    ld_bnum  = 2'd0;
    msg_done = (state == DONE);
    k_reset  = reset | (state == CORE_RST);
    case (state)
      FILL: begin
        if (pend) begin
          // Short last word accepted while the hold slot was busy: flush it now.
          if (hold_free) begin
            ld      = 1'b1;
            ld_data = mk_word(acc, cnt);
            ld_last = 1'b1;
            ld_bnum = cnt;
          end
        end else begin
          s_ready = ~reset & ~(k_in_ready & ~xfer & (cnt == 2'd3) & s_valid);
          accept  = s_valid & s_ready;
          if (accept) begin
            if (cnt == 2'd3) begin
              ld      = 1'b1;
              ld_data = {acc, s_byte};
            end else if (s_last && hold_free) begin
              ld      = 1'b1;
              ld_data = mk_word(acc_ins, cnt + 2'd1);
              ld_last = 1'b1;
              ld_bnum = cnt + 2'd1;
            end
          end
        end
      end
      PAD: begin
        if (hold_free) begin
          ld      = 1'b1;
          ld_data = PAD_ZERO ? 32'h0000_0000 : k_in;
          ld_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath: accumulator, byte count, hold register and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      cnt        <= '0;
      pend       <= 1'b0;
      k_in       <= '0;
      k_in_ready <= 1'b0;
      k_is_last  <= 1'b0;
      k_byte_num <= '0;
      busy       <= 1'b0;
    end else begin
      if (accept) begin
        acc <= acc_ins;
        cnt <= cnt + 2'd1;
      end else if (state == CORE_RST) begin
        cnt <= '0;
      end

      if (accept && s_last && (cnt != 2'd3) && !hold_free) pend <= 1'b1;
      else if (ld || state == CORE_RST)                     pend <= 1'b0;

      if (ld) begin
        k_in       <= ld_data;
        k_is_last  <= ld_last;
        k_byte_num <= ld_bnum;
        k_in_ready <= 1'b1;
      end else if (xfer) begin
        k_in_ready <= 1'b0;
      end

      if (accept)              busy <= 1'b1;
      else if (state == DONE)  busy <= 1'b0;
    end
  end

`ifdef KECCAK_FEEDER_LENCNT_EN
  // Saturating count of bytes accepted in the current message.
  always_ff @(posedge clk) begin
    if (reset || state == CORE_RST) msg_len <= '0;
    else if (accept && msg_len != '1) msg_len <= msg_len + 32'd1;
  end
`endif

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Directed bench for keccak_msg_feeder: packing, stall, padding, message
// completion sequence and mid-message reset.
module tb_keccak_msg_feeder;

  logic        clk;
  logic        reset;
  logic [7:0]  s_byte;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] k_in;
  logic        k_in_ready;
  logic        k_is_last;
  logic [1:0]  k_byte_num;
  logic        k_buffer_full;
  logic        k_out_ready;
  logic        k_reset;
  logic        msg_done;
  logic        busy;
`ifdef KECCAK_FEEDER_LENCNT_EN
  logic [31:0] msg_len;
`endif

  keccak_msg_feeder #(.PAD_ZERO(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_byte        (s_byte),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .k_in          (k_in),
    .k_in_ready    (k_in_ready),
    .k_is_last     (k_is_last),
    .k_byte_num    (k_byte_num),
    .k_buffer_full (k_buffer_full),
    .k_out_ready   (k_out_ready),
    .k_reset       (k_reset),
    .msg_done      (msg_done),
`ifdef KECCAK_FEEDER_LENCNT_EN
    .msg_len       (msg_len),
`endif
    .busy          (busy)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int unsigned sent_len = 0;
  logic [34:0] wq[$];   // {is_last, byte_num, data} of each transferred word

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Words are captured on the falling edge preceding the transfer edge.
  always @(negedge clk)
    if (!reset && k_in_ready && !k_buffer_full)
      wq.push_back({k_is_last, k_byte_num, k_in});

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] wd(input logic last, input logic [1:0] bn, input logic [31:0] d);
    return {last, bn, d};
  endfunction

  task automatic chk_word(input string tag, input int unsigned idx, input logic [34:0] exp);
    logic [34:0] obs;
    obs = (idx < wq.size()) ? wq[idx] : 'x;
    chk(tag, obs, exp);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input logic last, output bit timeout);
    int unsigned n;
    n = 0;
    timeout = 1'b0;
    s_byte = b; s_valid = 1'b1; s_last = last;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 200) begin timeout = 1'b1; break; end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    if (!timeout) sent_len++;
  endtask

  task automatic send_str(input string tag, input string s, input bit with_last);
    bit to, any_to;
    any_to = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], with_last && (i == s.len() - 1), to);
      any_to |= to;
    end
    chk({tag, "_accept"}, any_to, 1'b0);
  endtask

  // Waits for n words, raises k_out_ready 10 cycles later and checks the
  // msg_done / k_reset / s_ready sequence that follows.
  task automatic finish_msg(input string tag, input int unsigned n_words);
    int unsigned t;
    t = 0;
    while (wq.size() < n_words && t < 300) begin
      @(posedge clk); #1; t++;
    end
    chk({tag, "_nwords"}, wq.size(), n_words);
    repeat (10) @(posedge clk);
    #1 k_out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_early"}, msg_done, 1'b0);
    @(posedge clk); #1 k_out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done"}, msg_done, 1'b1);
    chk({tag, "_krst_early"}, k_reset, 1'b0);
    chk({tag, "_busy_done"}, busy, 1'b1);
`ifdef KECCAK_FEEDER_LENCNT_EN
    chk({tag, "_len"}, msg_len, sent_len);
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, msg_done, 1'b0);
    chk({tag, "_krst"}, k_reset, 1'b1);
    chk({tag, "_sready_rst"}, s_ready, 1'b0);
    @(negedge clk);
    chk({tag, "_krst_end"}, k_reset, 1'b0);
    chk({tag, "_sready_back"}, s_ready, 1'b1);
    chk({tag, "_busy_end"}, busy, 1'b0);
`ifdef KECCAK_FEEDER_LENCNT_EN
    chk({tag, "_len_clr"}, msg_len, 32'd0);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] held;
    bit          have, stalled;

    reset = 1'b1; s_byte = 8'h00; s_valid = 1'b0; s_last = 1'b0;
    k_buffer_full = 1'b0; k_out_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_krst", k_reset, 1'b1);
    chk("rst_sready", s_ready, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_kin", k_in, 32'h0);
    chk("rst_inrdy", k_in_ready, 1'b0);
    chk("rst_last", k_is_last, 1'b0);
    chk("rst_bnum", k_byte_num, 2'd0);
    chk("rst_done", msg_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_krst_off", k_reset, 1'b0);
    chk("rst_sready_up", s_ready, 1'b1);
    @(posedge clk); #1;

    // "abc": single partial last word.
    wq.delete(); sent_len = 0;
    send_str("abc", "abc", 1'b1);
    finish_msg("abc", 1);
    chk_word("abc_w0", 0, wd(1'b1, 2'd3, 32'h6162_6300));

    // "Hello, world": three full words followed by an empty pad word.
    wq.delete(); sent_len = 0;
    send_str("hello", "Hello, world", 1'b1);
    finish_msg("hello", 4);
    chk_word("hello_w0", 0, wd(1'b0, 2'd0, 32'h4865_6C6C));
    chk_word("hello_w1", 1, wd(1'b0, 2'd0, 32'h6F2C_2077));
    chk_word("hello_w2", 2, wd(1'b0, 2'd0, 32'h6F72_6C64));
    chk_word("hello_w3", 3, wd(1'b1, 2'd0, 32'h0000_0000));

    // Streaming with a 6-cycle buffer_full stall mid-message.
    wq.delete(); sent_len = 0;
    held = '0; have = 1'b0; stalled = 1'b0;
    fork
      send_str("fox", "The quick brown fox.", 1'b1);
      begin
        repeat (6) @(posedge clk);
        #1 k_buffer_full = 1'b1;
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          if (k_in_ready) begin
            if (have) chk("stall_hold", k_in, held);
            else begin held = k_in; have = 1'b1; end
          end
          if (s_valid && !s_ready) stalled = 1'b1;
        end
        @(posedge clk); #1 k_buffer_full = 1'b0;
      end
    join
    chk("stall_word", held, 32'h7175_6963);
    chk("stall_sready_drop", stalled, 1'b1);
    finish_msg("fox", 6);
    chk_word("fox_w0", 0, wd(1'b0, 2'd0, 32'h5468_6520));
    chk_word("fox_w1", 1, wd(1'b0, 2'd0, 32'h7175_6963));
    chk_word("fox_w2", 2, wd(1'b0, 2'd0, 32'h6B20_6272));
    chk_word("fox_w3", 3, wd(1'b0, 2'd0, 32'h6F77_6E20));
    chk_word("fox_w4", 4, wd(1'b0, 2'd0, 32'h666F_782E));
    chk_word("fox_w5", 5, wd(1'b1, 2'd0, 32'h0000_0000));

    // "abcde" with the core buffer full: short last word waits behind a held word.
    wq.delete(); sent_len = 0;
    k_buffer_full = 1'b1;
    send_str("pend", "abcde", 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pend_hold", k_in, 32'h6162_6364);
    chk("pend_inrdy", k_in_ready, 1'b1);
    chk("pend_sready", s_ready, 1'b0);
    @(posedge clk); #1 k_buffer_full = 1'b0;
    finish_msg("pend", 2);
    chk_word("pend_w0", 0, wd(1'b0, 2'd0, 32'h6162_6364));
    chk_word("pend_w1", 1, wd(1'b1, 2'd1, 32'h6500_0000));

    // Reset after 5 bytes of a message.
    send_str("part", "ABCDE", 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_krst", k_reset, 1'b1);
    chk("mid_sready", s_ready, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_kin", k_in, 32'h0);
    chk("mid_inrdy", k_in_ready, 1'b0);
    chk("mid_last", k_is_last, 1'b0);
    chk("mid_bnum", k_byte_num, 2'd0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_done", msg_done, 1'b0);
    chk("mid_krst_off", k_reset, 1'b0);
    chk("mid_sready_up", s_ready, 1'b1);
    @(posedge clk); #1;
    wq.delete(); sent_len = 0;
    send_str("bang", "!", 1'b1);
    finish_msg("bang", 1);
    chk_word("bang_w0", 0, wd(1'b1, 2'd1, 32'h2100_0000));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
